// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the button-controlled PWM dimmer.
// Holds default configuration values, the derived default widths, the
// tile I/O bit positions and the saturating duty-step functions.
package pwm_pkg;

    // Default configuration of the tile.
    localparam int unsigned CLK_HZ_DEF     = 10_000;
    localparam int unsigned DUTY_MAX_DEF   = 10;
    localparam int unsigned DUTY_RST_DEF   = 5;
    localparam int unsigned DEB_CYCLES_DEF = 100;

    // Register widths for the default configuration; the top re-derives them
    // from its own parameters so that overrides stay consistent.
    localparam int unsigned DUTY_W = $clog2(DUTY_MAX_DEF + 1);
    localparam int unsigned DIV_W  = $clog2(CLK_HZ_DEF / 2);

    // Input pad bit positions.
    localparam int unsigned IO_CLK   = 0;
    localparam int unsigned IO_INCR  = 1;
    localparam int unsigned IO_DECR  = 2;
    localparam int unsigned IO_RST_N = 3;

    // Output pad bit positions.
    localparam int unsigned OUT_CLK_1HZ = 0;
    localparam int unsigned OUT_LED     = 1;
    localparam int unsigned OUT_DELED   = 2;
    localparam int unsigned OUT_INLED   = 3;

    // One step up, never beyond max_value.
    function automatic int unsigned sat_inc(input int unsigned value,
                                            input int unsigned max_value);
        return (value >= max_value) ? max_value : value + 1;
    endfunction

    // One step down, never below zero.
    function automatic int unsigned sat_dec(input int unsigned value);
        return (value == 0) ? 0 : value - 1;
    endfunction

endpackage

// File: rtl/pwm_gen_btn_sync_edge.sv
// btn_sync_edge: brings a raw asynchronous push-button into the clock domain,
// optionally debounces it, and produces a one-cycle pulse per rising edge.
// Configuration macro: PWM_DEBOUNCE_EN enables the stable-sample debounce.
module btn_sync_edge #(
    parameter int unsigned DEB_CYCLES = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    logic sync_meta;
    logic sync_q;
    logic level_d;

    // Two-flop synchronizer for the asynchronous pad input.
    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the value from before the edge, which is what makes the chain a
    // chain instead of collapsing into a single register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
        end
    end

`ifdef PWM_DEBOUNCE_EN
    localparam int unsigned DEB_BITS = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_CYCLES - 1);

    logic                deb_q;
    logic [DEB_BITS-1:0] deb_cnt;

    // Accept a new level only after it has differed from the current one for
    // DEB_CYCLES consecutive samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else if (sync_q == deb_q) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_q   <= sync_q;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign level = deb_q;
`else
    // Without debounce the synchronized level is used directly.
    logic [31:0] unused_deb_cycles;
    assign unused_deb_cycles = DEB_CYCLES;
    assign level = sync_q;
`endif

    // Delayed copy of the level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // One pulse per press no matter how long the button is held.
    assign pulse = level & ~level_d;

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: button-controlled PWM LED dimmer for an 8-in/8-out tile.
// Two buttons step the duty register up/down with saturation, led carries the
// PWM waveform, clock_1hz is a free-running 50 % square wave and inled/deled
// mirror the conditioned button levels.
// Configuration macro: PWM_DEBOUNCE_EN (see btn_sync_edge).
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
    parameter int unsigned DUTY_MAX   = DUTY_MAX_DEF,
    parameter int unsigned DUTY_RST   = DUTY_RST_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int unsigned DUTY_BITS = $clog2(DUTY_MAX + 1);
    localparam int unsigned HALF_HZ   = CLK_HZ / 2;
    localparam int unsigned DIV_BITS  = (HALF_HZ > 1) ? $clog2(HALF_HZ) : 1;

    localparam logic [DUTY_BITS-1:0] PWM_LAST  = DUTY_BITS'(DUTY_MAX - 1);
    localparam logic [DUTY_BITS-1:0] DUTY_INIT = DUTY_BITS'(DUTY_RST);
    localparam logic [DIV_BITS-1:0]  DIV_LAST  = DIV_BITS'(HALF_HZ - 1);

    logic clk;
    logic rst_n;

    logic incr_level;
    logic incr_pulse;
    logic decr_level;
    logic decr_pulse;

    logic [DUTY_BITS-1:0] duty_q;
    logic [DUTY_BITS-1:0] pwm_cnt_q;
    logic [DIV_BITS-1:0]  div_cnt_q;
    logic                 led_q;
    logic                 clock_1hz_q;

    assign clk   = io_in[IO_CLK];
    assign rst_n = io_in[IO_RST_N];

    // The upper pads carry nothing for this tile.
    logic unused_io;
    assign unused_io = ^io_in[7:4];

    btn_sync_edge #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_incr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (io_in[IO_INCR]),
        .level (incr_level),
        .pulse (incr_pulse)
    );

    btn_sync_edge #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_decr (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (io_in[IO_DECR]),
        .level (decr_level),
        .pulse (decr_pulse)
    );

    // Duty register: saturating step per press, simultaneous presses cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= DUTY_INIT;
        end else begin
            unique case ({incr_pulse, decr_pulse})
                2'b10:   duty_q <= DUTY_BITS'(sat_inc(int'(duty_q), DUTY_MAX));
                2'b01:   duty_q <= DUTY_BITS'(sat_dec(int'(duty_q)));
                default: duty_q <= duty_q;
            endcase
        end
    end

    // PWM period counter and registered comparator; a duty change is seen
    // on the very next comparison rather than at the period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            led_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
            led_q     <= (pwm_cnt_q < duty_q);
        end
    end

    // Half-period divider for the 1 Hz square wave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            clock_1hz_q <= 1'b0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_q   <= '0;
            clock_1hz_q <= ~clock_1hz_q;
        end else begin
            div_cnt_q   <= div_cnt_q + 1'b1;
        end
    end

    // Output pad packing; unused pads are driven low.
    // NOTE: the blanket default first keeps every bit assigned on every pass,
    // so no latch can be inferred when individual bits are filled in below.
    always_comb begin
        io_out              = '0;
        io_out[OUT_CLK_1HZ] = clock_1hz_q;
        io_out[OUT_LED]     = led_q;
        io_out[OUT_DELED]   = decr_level;
        io_out[OUT_INLED]   = incr_level;
    end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed, table-driven bench for pwm_gen. A second instance
// with CLK_HZ=10 shares the pads so the 1 Hz divider can be checked quickly.
module tb_pwm_gen;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic btn_incr = 1'b0;
    logic btn_decr = 1'b0;

    logic [7:0] io_in;
    logic [7:0] io_out_a;
    logic [7:0] io_out_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Upper pads carry a non-zero pattern to show they are ignored.
    assign io_in = {4'b1010, rst_n, btn_decr, btn_incr, clk};

    always #5 clk = ~clk;

    pwm_gen dut_a (
        .io_in  (io_in),
        .io_out (io_out_a)
    );

    pwm_gen #(
        .CLK_HZ (10)
    ) dut_b (
        .io_in  (io_in),
        .io_out (io_out_b)
    );

    typedef struct {
        string name;
        int    n_decr;
        int    n_incr;
        int    n_both;
        int    exp_duty;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn_incr = 1'b0;
        btn_decr = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
    endtask

    // One clean press: held three clocks, released four.
    task automatic press(input logic inc, input logic dec);
        btn_incr = inc;
        btn_decr = dec;
        repeat (3) tick();
        btn_incr = 1'b0;
        btn_decr = 1'b0;
        repeat (4) tick();
    endtask

    // Count led-high clocks over two PWM periods; also watch the tied pads.
    task automatic measure_led(input string name, input int exp_duty);
        int hi;
        int upper_bad;
        hi        = 0;
        upper_bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            hi += int'(io_out_a[1]);
            if (io_out_a[7:4] != 4'h0) upper_bad++;
        end
        check(name, hi, 2 * exp_duty);
        check({name, "_upper_zero"}, upper_bad, 0);
    endtask

    initial begin
        vecs[0] = '{"idle_duty5",      0, 0, 0, 5};
        vecs[1] = '{"incr3_duty8",     0, 3, 0, 8};
        vecs[2] = '{"decr12_sat0",    12, 0, 0, 0};
        vecs[3] = '{"decr12_incr1",   12, 1, 0, 1};
        vecs[4] = '{"incr7_sat10",     0, 7, 0, 10};
        vecs[5] = '{"both_same_cycle", 0, 0, 1, 5};
        vecs[6] = '{"decr2_duty3",     2, 0, 0, 3};
        vecs[7] = '{"incr4_both2",     0, 4, 2, 9};

        // Asynchronous reset: outputs clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_out_a", int'(io_out_a), 0);
        check("reset_out_b", int'(io_out_b), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Exact waveforms after release: led high on clocks 1..5 of each
        // period, clock_1hz first toggles on the fifth clock.
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("led_phase_%0d", k), int'(io_out_a[1]),
                  (((k - 1) % 10) < 5) ? 1 : 0);
            check($sformatf("clk1hz_%0d", k), int'(io_out_b[0]), (k / 5) % 2);
        end
        check("upper_pads_a", int'(io_out_a[7:4]), 0);

        // Indicator latency: two clocks from pad to indicator, both edges.
        btn_incr = 1'b1;
        tick();
        check("inled_lat1_rise", int'(io_out_a[3]), 0);
        tick();
        check("inled_lat2_rise", int'(io_out_a[3]), 1);
        btn_incr = 1'b0;
        tick();
        check("inled_lat1_fall", int'(io_out_a[3]), 1);
        tick();
        check("inled_lat2_fall", int'(io_out_a[3]), 0);
        btn_decr = 1'b1;
        tick();
        check("deled_lat1_rise", int'(io_out_a[2]), 0);
        tick();
        check("deled_lat2_rise", int'(io_out_a[2]), 1);
        check("deled_no_inled", int'(io_out_a[3]), 0);
        btn_decr = 1'b0;
        tick();
        tick();
        check("deled_fall", int'(io_out_a[2]), 0);

        // Table of press sequences and resulting duty.
        foreach (vecs[i]) begin
            do_reset();
            repeat (vecs[i].n_decr) press(1'b0, 1'b1);
            repeat (vecs[i].n_incr) press(1'b1, 1'b0);
            repeat (vecs[i].n_both) press(1'b1, 1'b1);
            measure_led(vecs[i].name, vecs[i].exp_duty);
        end

        // Holding the button for 50 clocks gives exactly one step.
        do_reset();
        btn_incr = 1'b1;
        repeat (50) tick();
        check("held_inled", int'(io_out_a[3]), 1);
        btn_incr = 1'b0;
        repeat (4) tick();
        measure_led("held_incr_one_step", 6);

        // Reset mid-PWM at duty 9, between clock edges, while led is high.
        do_reset();
        repeat (4) press(1'b1, 1'b0);
        begin
            int waited;
            waited = 0;
            while (io_out_a[1] != 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            check("mid_led_high_before_reset", int'(io_out_a[1]), 1);
        end
        #3 rst_n = 1'b0;
        #1;
        check("mid_reset_out_a", int'(io_out_a), 0);
        check("mid_reset_out_b", int'(io_out_b), 0);
        tick();
        tick();
        rst_n = 1'b1;
        measure_led("mid_reset_duty5", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
